ov7670_grid_capture_ctrl: RTL and testbench

//  Parametrised capture controller for the OV7670 serial link: requests one frame, counts the

---
 rtl/ov7670_pkg.sv | 19 +
 rtl/ov7670_pixel_locator.sv | 92 +++++++++
 rtl/ov7670_grid_capture_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ov7670_grid_capture_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture units: FSM state encoding (doubles as the
// db_estado debug code) and a width helper for counters.
package ov7670_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQUEST = 4'd1,
        ST_WAIT_TX = 4'd2,
        ST_RECEIVE = 4'd3,
        ST_DONE    = 4'd4,
        ST_ERROR   = 4'd5
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ov7670_pixel_locator.sv
// Tracks where the current stream byte sits in the frame (byte within pixel, position inside
// the current grid cell, cell indices) and flags sample points and the last byte of the frame.
module ov7670_pixel_locator
    import ov7670_pkg::*;
#(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int BYTES_PX    = 2,
    parameter int SAMPLE_BYTE = 0,
    parameter int GRID        = 3,
    parameter int ADDR_W      = cnt_w(GRID * GRID)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic              sample_hit,
    output logic              last_byte,
    output logic [ADDR_W-1:0] cell_addr
);

    localparam int CELL_W = IMG_W / GRID;
    localparam int CELL_H = IMG_H / GRID;
    localparam int BW     = cnt_w(BYTES_PX);
    localparam int XW     = cnt_w(CELL_W);
    localparam int YW     = cnt_w(CELL_H);
    localparam int GW     = cnt_w(GRID);

    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_PX - 1);
    localparam logic [BW-1:0] BYTE_SMP  = BW'(SAMPLE_BYTE);
    localparam logic [XW-1:0] X_LAST    = XW'(CELL_W - 1);
    localparam logic [XW-1:0] X_MID     = XW'(CELL_W / 2);
    localparam logic [YW-1:0] Y_LAST    = YW'(CELL_H - 1);
    localparam logic [YW-1:0] Y_MID     = YW'(CELL_H / 2);
    localparam logic [GW-1:0] G_LAST    = GW'(GRID - 1);

    logic [BW-1:0] byte_r;
    logic [XW-1:0] x_r;
    logic [GW-1:0] cx_r;
    logic [YW-1:0] y_r;
    logic [GW-1:0] cy_r;

    // Position walk: byte -> column inside cell -> cell column -> line inside cell -> cell row
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_r <= '0;
            x_r    <= '0;
            cx_r   <= '0;
            y_r    <= '0;
            cy_r   <= '0;
        end else if (clear) begin
            byte_r <= '0;
            x_r    <= '0;
            cx_r   <= '0;
            y_r    <= '0;
            cy_r   <= '0;
        end else if (advance) begin
            if (byte_r == BYTE_LAST) begin
                byte_r <= '0;
                if (x_r == X_LAST) begin
                    x_r <= '0;
                    if (cx_r == G_LAST) begin
                        cx_r <= '0;
                        if (y_r == Y_LAST) begin
                            y_r  <= '0;
                            cy_r <= (cy_r == G_LAST) ? '0 : cy_r + GW'(1'b1);
                        end else begin
                            y_r <= y_r + YW'(1'b1);
                        end
                    end else begin
                        cx_r <= cx_r + GW'(1'b1);
                    end
                end else begin
                    x_r <= x_r + XW'(1'b1);
                end
            end else begin
                byte_r <= byte_r + BW'(1'b1);
            end
        end else begin
            byte_r <= byte_r;
        end
    end

    // Flags describe the byte arriving now, before the counters step past it
    always_comb begin
        sample_hit = (byte_r == BYTE_SMP) && (x_r == X_MID) && (y_r == Y_MID);
        last_byte  = (byte_r == BYTE_LAST) && (x_r == X_LAST) && (cx_r == G_LAST)
                     && (y_r == Y_LAST) && (cy_r == G_LAST);
        cell_addr  = ADDR_W'(cy_r) * ADDR_W'(GRID) + ADDR_W'(cx_r);
    end

endmodule

// File: rtl/ov7670_grid_capture_ctrl.sv
// OV7670 frame capture controller: requests a frame over serial TX, walks the returned byte
// stream and writes one sample byte per grid cell, with timeout, abort and done/error reporting.
module ov7670_grid_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int BYTES_PX    = 2,
    parameter int SAMPLE_BYTE = 0,
    parameter int GRID        = 3,
    parameter int TIMEOUT     = 1000000,
    parameter int ADDR_W      = cnt_w(GRID * GRID)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    output logic              tx_start,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic              erro,
    output logic [3:0]        db_estado
);

    localparam int            TW       = cnt_w(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    generate
        if ((IMG_W % GRID) != 0 || (IMG_H % GRID) != 0) begin : g_bad_grid
            $error("ov7670_grid_capture_ctrl: IMG_W and IMG_H must be multiples of GRID");
        end
        if (BYTES_PX < 1 || BYTES_PX > 4 || SAMPLE_BYTE < 0 || SAMPLE_BYTE >= BYTES_PX) begin : g_bad_bytes
            $error("ov7670_grid_capture_ctrl: need 1 <= BYTES_PX <= 4 and SAMPLE_BYTE < BYTES_PX");
        end
    endgenerate

    state_t            state_r;
    state_t            state_n;
    logic              start_s;
    logic              accept_s;
    logic              tmo_hit_s;
    logic              sample_hit_s;
    logic              last_byte_s;
    logic [ADDR_W-1:0] cell_addr_s;
    logic [TW-1:0]     tmo_cnt_r;

    logic              tx_start_r;
    logic              we_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [7:0]        wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              erro_r;

    ov7670_pixel_locator #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BYTES_PX   (BYTES_PX),
        .SAMPLE_BYTE(SAMPLE_BYTE),
        .GRID       (GRID),
        .ADDR_W     (ADDR_W)
    ) u_locator (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_s),
        .advance   (accept_s),
        .sample_hit(sample_hit_s),
        .last_byte (last_byte_s),
        .cell_addr (cell_addr_s)
    );

    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Next state; abortar outranks every other transition outside IDLE
    always_comb begin
        state_n  = state_r;
        start_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iniciar) begin
                    state_n = ST_REQUEST;
                    start_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (abortar) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (abortar) begin
                    state_n = ST_IDLE;
                end else if (tx_done) begin
                    state_n = ST_RECEIVE;
                end else if (tmo_hit_s) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_WAIT_TX;
                end
            end
            ST_RECEIVE: begin
                if (abortar) begin
                    state_n = ST_IDLE;
                end else if (rx_valid) begin
                    accept_s = 1'b1;
                    state_n  = last_byte_s ? ST_DONE : ST_RECEIVE;
                end else if (tmo_hit_s) begin
                    state_n = ST_ERROR;
                end else begin
                    state_n = ST_RECEIVE;
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            ST_ERROR: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Watchdog: restarts on every state change and on each byte received
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if ((state_n != state_r) || (state_r == ST_RECEIVE && rx_valid)) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_WAIT_TX || state_r == ST_RECEIVE) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Output registers, decoded from the next state so they line up with the state they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_start_r <= 1'b0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            erro_r     <= 1'b0;
        end else begin
            tx_start_r <= (state_n == ST_REQUEST);
            busy_r     <= (state_n == ST_REQUEST) || (state_n == ST_WAIT_TX) || (state_n == ST_RECEIVE);
            done_r     <= (state_n == ST_DONE);
            we_r       <= accept_s && sample_hit_s;
            if (accept_s && sample_hit_s) begin
                waddr_r <= cell_addr_s;
                wdata_r <= rx_data;
            end else begin
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
            end
            if (start_s) begin
                erro_r <= 1'b0;
            end else if (state_n == ST_ERROR) begin
                erro_r <= 1'b1;
            end else begin
                erro_r <= erro_r;
            end
        end
    end

    assign tx_start  = tx_start_r;
    assign we        = we_r;
    assign waddr     = waddr_r;
    assign wdata     = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign erro      = erro_r;
    assign db_estado = state_r;

endmodule

// File: tb/tb_ov7670_grid_capture_ctrl.sv
// Bench for ov7670_grid_capture_ctrl: two instances (SAMPLE_BYTE 0 and 1) share one stimulus
// stream; writes are compared against a frame-arithmetic reference model.
module tb_ov7670_grid_capture_ctrl;

    localparam int IMG_W       = 6;
    localparam int IMG_H       = 6;
    localparam int BYTES_PX    = 2;
    localparam int GRID        = 3;
    localparam int TIMEOUT     = 50;
    localparam int ADDR_W      = 4;
    localparam int FRAME_BYTES = IMG_W * IMG_H * BYTES_PX;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar, abortar, tx_done, rx_valid;
    logic [7:0]        rx_data;
    logic              tx_start0, we0, busy0, done0, erro0;
    logic              tx_start1, we1, busy1, done1, erro1;
    logic [ADDR_W-1:0] waddr0, waddr1;
    logic [7:0]        wdata0, wdata1;
    logic [3:0]        db0, db1;

    always #5 clock = ~clock;

    ov7670_grid_capture_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BYTES_PX(BYTES_PX), .SAMPLE_BYTE(0),
        .GRID(GRID), .TIMEOUT(TIMEOUT)
    ) dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
        .tx_start(tx_start0), .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
        .we(we0), .waddr(waddr0), .wdata(wdata0), .busy(busy0), .done(done0),
        .erro(erro0), .db_estado(db0)
    );

    ov7670_grid_capture_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BYTES_PX(BYTES_PX), .SAMPLE_BYTE(1),
        .GRID(GRID), .TIMEOUT(TIMEOUT)
    ) dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
        .tx_start(tx_start1), .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
        .we(we1), .waddr(waddr1), .wdata(wdata1), .busy(busy1), .done(done1),
        .erro(erro1), .db_estado(db1)
    );

    typedef struct { int addr; int data; } wr_t;

    typedef struct {
        string name;
        int    nbytes;
        bit    give_tx;
        int    abort_at;
        int    exp_done;
        int    exp_erro;
        int    exp_w0;
        int    exp_w1;
    } scen_t;

    wr_t        got0[$], got1[$], exp0[$], exp1[$];
    int         done_n0, done_n1, txs_n;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] frame_b [0:FRAME_BYTES+7];
    scen_t      tbl [6];

    always @(negedge clock) begin
        if (we0 === 1'b1) got0.push_back('{int'(waddr0), int'(wdata0)});
        if (we1 === 1'b1) got1.push_back('{int'(waddr1), int'(wdata1)});
        if (done0 === 1'b1) done_n0++;
        if (done1 === 1'b1) done_n1++;
        if (tx_start0 === 1'b1) txs_n++;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit ab, input bit ini);
        rx_valid = 1'b1; rx_data = b; abortar = ab; iniciar = ini;
        tick();
        rx_valid = 1'b0; abortar = 1'b0; iniciar = 1'b0;
    endtask

    // Reference: the first n_acc stream bytes mapped to (row, col, byte) by plain arithmetic.
    function automatic void build_exp(input int n_acc);
        int  cw, ch, px, b, row, col;
        wr_t w;
        exp0.delete();
        exp1.delete();
        cw = IMG_W / GRID;
        ch = IMG_H / GRID;
        for (int k = 0; k < n_acc; k++) begin
            px  = k / BYTES_PX;
            b   = k % BYTES_PX;
            row = px / IMG_W;
            col = px % IMG_W;
            if ((row % ch) == ch / 2 && (col % cw) == cw / 2) begin
                w.addr = (row / ch) * GRID + col / cw;
                w.data = int'(frame_b[k]);
                if (b == 0) exp0.push_back(w);
                if (b == 1) exp1.push_back(w);
            end
        end
    endfunction

    task automatic cmp_writes(input string nm, input int sel);
        int n;
        if (sel == 0) begin
            n = (got0.size() < exp0.size()) ? got0.size() : exp0.size();
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s:w0[%0d].addr", nm, i), got0[i].addr, exp0[i].addr);
                chk($sformatf("%s:w0[%0d].data", nm, i), got0[i].data, exp0[i].data);
            end
        end else begin
            n = (got1.size() < exp1.size()) ? got1.size() : exp1.size();
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s:w1[%0d].addr", nm, i), got1[i].addr, exp1[i].addr);
                chk($sformatf("%s:w1[%0d].data", nm, i), got1[i].data, exp1[i].data);
            end
        end
    endtask

    task automatic run_scen(input scen_t s, input bit rnd);
        int n_acc;
        int wcyc;
        got0.delete(); got1.delete();
        done_n0 = 0; done_n1 = 0; txs_n = 0;
        n_acc = 0; wcyc = 0;
        drive_byte(8'h5A, 1'b0, 1'b0);             // stray byte in IDLE
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        chk({s.name, ":state_request"}, int'(db0), 1);
        chk({s.name, ":tx_start_high"}, int'(tx_start0), 1);
        chk({s.name, ":busy_high"}, int'(busy0), 1);
        chk({s.name, ":erro_cleared"}, int'(erro0), 0);
        drive_byte(8'hA5, 1'b0, 1'b0);             // stray byte in REQUEST
        chk({s.name, ":state_wait_tx"}, int'(db0), 2);
        chk({s.name, ":tx_start_low"}, int'(tx_start0), 0);
        if (s.give_tx) begin
            drive_byte(8'hC3, 1'b0, 1'b0);         // stray byte in WAIT_TX
            tx_done = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
            tick();
            tx_done = 1'b0; rx_valid = 1'b0;
            for (int k = 0; k < s.nbytes; k++) begin
                if (rnd) repeat ($urandom_range(0, 3)) tick();
                if (k == s.abort_at) begin
                    drive_byte(frame_b[k], 1'b1, 1'b0);
                    chk({s.name, ":abort_to_idle"}, int'(db0), 0);
                    break;
                end
                drive_byte(frame_b[k], 1'b0, rnd && ($urandom_range(0, 7) == 0));
                n_acc = (k < FRAME_BYTES) ? k + 1 : FRAME_BYTES;
            end
        end
        for (int c = 0; c < 400 && busy0; c++) begin
            if (db0 == 4'd2) wcyc++;
            tick();
        end
        chk({s.name, ":idle_within_bound"}, int'(busy0), 0);
        if (!s.give_tx) chk({s.name, ":wait_tx_cycles"}, wcyc, TIMEOUT);
        repeat (3) tick();
        chk({s.name, ":done0_pulses"}, done_n0, s.exp_done);
        chk({s.name, ":done1_pulses"}, done_n1, s.exp_done);
        chk({s.name, ":erro0"}, int'(erro0), s.exp_erro);
        chk({s.name, ":erro1"}, int'(erro1), s.exp_erro);
        chk({s.name, ":tx_start_pulses"}, txs_n, 1);
        chk({s.name, ":we0_count"}, got0.size(), s.exp_w0);
        chk({s.name, ":we1_count"}, got1.size(), s.exp_w1);
        build_exp(n_acc);
        cmp_writes(s.name, 0);
        cmp_writes(s.name, 1);
    endtask

    task automatic chk_spec_points();
        if (got0.size() >= 9 && got1.size() >= 9) begin
            chk("pt:w0[0].addr", got0[0].addr, 0);  chk("pt:w0[0].data", got0[0].data, 14);
            chk("pt:w0[1].addr", got0[1].addr, 1);  chk("pt:w0[1].data", got0[1].data, 18);
            chk("pt:w0[8].addr", got0[8].addr, 8);  chk("pt:w0[8].data", got0[8].data, 70);
            chk("pt:w1[0].addr", got1[0].addr, 0);  chk("pt:w1[0].data", got1[0].data, 15);
            chk("pt:w1[8].addr", got1[8].addr, 8);  chk("pt:w1[8].data", got1[8].data, 71);
        end else begin
            chk("pt:write_count", got0.size() + got1.size(), 18);
        end
    endtask

    initial begin
        tbl[0] = '{"full_frame",  72, 1'b1, -1, 1, 0, 9, 9};
        tbl[1] = '{"no_tx_done",   0, 1'b0, -1, 0, 1, 0, 0};
        tbl[2] = '{"stall_at_30", 31, 1'b1, -1, 0, 1, 3, 3};
        tbl[3] = '{"abort_at_20", 72, 1'b1, 20, 0, 0, 2, 2};
        tbl[4] = '{"restart",     72, 1'b1, -1, 1, 0, 9, 9};
        tbl[5] = '{"extra_bytes", 76, 1'b1, -1, 1, 0, 9, 9};

        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; tx_done = 1'b0;
        rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        tick();
        chk("reset:db_estado", int'(db0), 0);
        chk("reset:busy", int'(busy0), 0);
        chk("reset:we", int'(we0), 0);
        chk("reset:tx_start", int'(tx_start0), 0);
        chk("reset:done", int'(done0), 0);
        chk("reset:erro", int'(erro0), 0);
        chk("reset:waddr", int'(waddr0), 0);
        chk("reset:wdata", int'(wdata0), 0);

        for (int k = 0; k < FRAME_BYTES + 8; k++) frame_b[k] = 8'(k);
        for (int i = 0; i < 6; i++) begin
            run_scen(tbl[i], 1'b0);
            if (i == 0) chk_spec_points();
        end

        // Asynchronous reset while a sample write is on the outputs
        got0.delete(); got1.delete();
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int k = 0; k < 15; k++) drive_byte(8'(k), 1'b0, 1'b0);
        chk("arst:we_pending", int'(we0), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst:db_estado", int'(db0), 0);
        chk("arst:we_dropped", int'(we0), 0);
        chk("arst:busy", int'(busy0), 0);
        #3 reset = 1'b0;
        repeat (4) tick();
        chk("arst:no_write0", got0.size(), 0);
        chk("arst:no_write1", got1.size(), 0);

        // Randomized frames: random bytes, gaps, stray iniciar, occasional abort
        for (int f = 0; f < 8; f++) begin
            scen_t s;
            int    ab;
            for (int k = 0; k < FRAME_BYTES; k++) frame_b[k] = 8'($urandom_range(0, 255));
            ab = (f % 2 == 1) ? int'($urandom_range(0, FRAME_BYTES - 1)) : -1;
            build_exp((ab < 0) ? FRAME_BYTES : ab);
            s = '{$sformatf("rand%0d", f), FRAME_BYTES, 1'b1, ab, (ab < 0) ? 1 : 0, 0,
                  exp0.size(), exp1.size()};
            run_scen(s, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
